// File: rtl/cube_unit_if.sv
// -----------------------------------------------------------------------------
// cube_unit_if -- start/busy handshake bundle for the iterative cube unit.
//
// Signals (W = operand/result width):
//   start   requester -> unit   request, sampled only while busy = 0
//   x_i     requester -> unit   operand, latched on the accepting edge
//   result  unit -> requester   registered cube result
//   ovf     unit -> requester   true x^3 did not fit in W bits
//   busy    unit -> requester   unit is not idle
//   done    unit -> requester   one-cycle completion pulse
//
// Modports: master = requester side, slave = cube unit side.
// -----------------------------------------------------------------------------
interface cube_unit_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] x_i;
  logic [W-1:0] result;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, x_i,
    input  result, ovf, busy, done
  );

  modport slave (
    input  start, x_i,
    output result, ovf, busy, done
  );
endinterface

// File: rtl/cube_unit.sv
// -----------------------------------------------------------------------------
// cube_unit -- iterative integer cube, result = x^3.
//
// One shift-add multiplier (W x W -> 2W, one multiplier bit per cycle) is used
// twice: first sq = x*x, then cu = sq[W-1:0]*x. There is no combinational
// multiplier; each step is a single 2W-bit add of a shifted multiplicand.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-low reset (0 = reset)
//   bus   slave modport of cube_unit_if (start, x_i, result, ovf, busy, done)
//
// Latency: busy is high for 2W+1 cycles after the accepting edge. With the
// optional macro CUBE_SAT_EN defined, an overflow already visible in the
// square exits early (W+1 cycles) and overflowed results saturate to all
// ones; without it the result is x^3 mod 2^W and ovf is still reported.
// -----------------------------------------------------------------------------
module cube_unit #(
  parameter int W = 16
) (
  input  logic       clk,
  input  logic       rst,
  cube_unit_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    CU   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t         state_q,  state_d;
  logic [W-1:0]   x_q,      x_d;
  logic [2*W-1:0] acc_q,    acc_d;
  logic [2*W-1:0] mcand_q,  mcand_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic           sq_ovf_q, sq_ovf_d;
  logic [W-1:0]   result_q, result_d;
  logic           ovf_q,    ovf_d;
  logic           done_q,   done_d;

  // One multiplier step: the multiplier is always x, the multiplicand is
  // pre-shifted in mcand_q so only an add is needed here.
  logic [2*W-1:0] acc_step;
  logic           last_iter;

  assign acc_step  = acc_q + (x_q[cnt_q] ? mcand_q : '0);
  assign last_iter = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      sq_ovf_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      sq_ovf_q <= sq_ovf_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    sq_ovf_d = sq_ovf_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d      = bus.x_i;
          acc_d    = '0;
          mcand_d  = {{W{1'b0}}, bus.x_i};
          cnt_d    = '0;
          sq_ovf_d = 1'b0;
          state_d  = SQ;
        end
      end

      SQ: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (last_iter) begin
          // Square complete: restart the multiplier on sq[W-1:0] * x.
          // Only the low half matters for the cube modulo 2^W; a non-zero
          // high half already proves x^3 >= 2^W.
          cnt_d    = '0;
          sq_ovf_d = |acc_step[2*W-1:W];
          acc_d    = '0;
          mcand_d  = {{W{1'b0}}, acc_step[W-1:0]};
          state_d  = CU;
`ifdef CUBE_SAT_EN
          if (|acc_step[2*W-1:W]) begin
            state_d = FIN;
          end
`endif
        end
      end

      CU: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (last_iter) begin
          cnt_d   = '0;
          state_d = FIN;
        end
      end

      FIN: begin
        // On the early-exit path acc_q is cleared, but sq_ovf_q carries
        // the overflow, so ovf is still correct.
        ovf_d = sq_ovf_q | (|acc_q[2*W-1:W]);
`ifdef CUBE_SAT_EN
        result_d = ovf_d ? {W{1'b1}} : acc_q[W-1:0];
`else
        result_d = acc_q[W-1:0];
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_cube_unit.sv
// -----------------------------------------------------------------------------
// tb_cube_unit -- scoreboard bench for cube_unit (W = 16).
// Stimulus pushes the expected {result, ovf, busy length} when it issues a
// request; an independent monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_cube_unit;

  localparam int W = 16;
`ifdef CUBE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           cyc;
    int           x;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t sb[$];

  cube_unit_if #(.W(W)) bus ();

  cube_unit #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard, measures the
  // busy length, and checks result/ovf hold between completions.
  initial begin : monitor
    int           bcnt;
    logic [W-1:0] prev_res;
    logic         prev_ovf;
    exp_t         e;
    bcnt     = 0;
    prev_res = '0;
    prev_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bcnt = 0;
      end else begin
        if (bus.busy) bcnt++;
        if (bus.done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("result x=%0d", e.x), int'(bus.result), int'(e.res));
            chk($sformatf("ovf x=%0d", e.x), int'(bus.ovf), int'(e.ovf));
            chk($sformatf("busy_cycles x=%0d", e.x), bcnt, e.cyc);
            $display("[TB] x=%0d result=%0d ovf=%0d busy=%0d", e.x, bus.result, bus.ovf, bcnt);
          end
          bcnt = 0;
        end else begin
          chk("result_hold", int'(bus.result), int'(prev_res));
          chk("ovf_hold", int'(bus.ovf), int'(prev_ovf));
        end
      end
      prev_res = bus.result;
      prev_ovf = bus.ovf;
    end
  end

  // Called at a falling edge; returns 1 ns after the accepting edge.
  task automatic issue(input int x, input int r, input bit o, input int c, input bit expect_it);
    exp_t e;
    bus.start = 1'b1;
    bus.x_i   = W'(x);
    if (expect_it) begin
      e.res = W'(r);
      e.ovf = o;
      e.cyc = c;
      e.x   = x;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk($sformatf("busy_after_accept x=%0d", x), int'(bus.busy), 1);
  endtask

  // Returns at the falling edge where done is high (bounded).
  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 200);
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.x_i   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",   int'(bus.busy),   0);
    chk("reset_result", int'(bus.result), 0);
    chk("reset_ovf",    int'(bus.ovf),    0);
    chk("reset_done",   int'(bus.done),   0);
    rst = 1'b1;
    @(negedge clk);

    // Each following request is issued on the done cycle of the previous one.
    issue(27, 19683, 1'b0, 33, 1'b1);                       wait_done();
    issue(40, 64000, 1'b0, 33, 1'b1);                       wait_done();
    issue(41, SAT ? 65535 : 3385, 1'b1, 33, 1'b1);          wait_done();
    issue(0, 0, 1'b0, 33, 1'b1);                            wait_done();
    issue(1, 1, 1'b0, 33, 1'b1);                            wait_done();
    issue(300, SAT ? 65535 : 64704, 1'b1, SAT ? 17 : 33, 1'b1); wait_done();
    repeat (2) @(negedge clk);

    // A start while busy must be neither queued nor re-latch x.
    issue(5, 125, 1'b0, 33, 1'b1);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.x_i   = W'(9);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);

    // Abort mid-operation: outputs clear at once, no done for this request.
    issue(27, 0, 1'b0, 0, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy",   int'(bus.busy),   0);
    chk("abort_result", int'(bus.result), 0);
    chk("abort_ovf",    int'(bus.ovf),    0);
    chk("abort_done",   int'(bus.done),   0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(3, 27, 1'b0, 33, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cube_unit.md
# cube_unit

Iterative integer cube unit computing `result = x_i^3`, the inverse of the cube-root block, with the same start/busy handshake. It sits beside the cube-root core so the bench and the datapath can round-trip values (cube then cube-root) and check them. It uses one internal shift-add multiplier, W×W→2W, one bit per cycle, run twice: square, then square×x. It has no combinational multiplier.

## Interface
- `W`, default 16: operand and result width. All cycle counts below are given for W=16 as 2W+1 / W+1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. 0 = reset.
- `start`  in  1  request. Sampled on a rising edge only while `busy`=0.
- `x_i`  in  W  operand. Latched on the accepting edge and ignored afterwards.
- `result`  out  W  cube result, registered. Holds until the next completion.
- `ovf`  out  1  set when the true x^3 ≥ 2^W. Registered together with `result`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after completion.

## Operation
- States:
  - IDLE
  - SQ: W iterations computing `sq = x*x` (2W bits)
  - CU: W iterations computing `cu = sq[W-1:0]*x` (2W bits)
  - FIN
- Multiplier step, per cycle:
  - If multiplier bit i = 1, add the shifted multiplicand into a 2W-bit accumulator.
  - Bit counter runs 0..W-1 and wraps to 0 on each state change.
- IDLE→SQ when `start`=1. Latch x and clear the accumulator.
- SQ→CU after the W-th iteration. Exception: with `CUBE_SAT_EN`, if `sq[2W-1:W]`≠0, go SQ→FIN with the overflow flagged.
- CU→FIN after the W-th iteration.
- FIN→IDLE unconditionally. In FIN:
  - `ovf` is set if `sq[2W-1:W]`≠0 or `cu[2W-1:W]`≠0.
  - `result` and `ovf` are written.
  - `done` is registered high for the following cycle.
- `start` while `busy`=1 is ignored. It is not queued and x is not re-latched.
- Reset values: `result`=0, `ovf`=0, `done`=0, `busy`=0, state IDLE.
- Reset asserted mid-operation aborts immediately to the reset values. No `done` pulse is issued for the aborted request.

## Timing
- Accepting edge is E0. `busy` is high from after E0.
- Normal path:
  - SQ occupies E1..E16.
  - CU occupies E17..E32.
  - FIN is acted on at E33.
  - `busy` falls, `done`=1 and `result`/`ovf` are valid after E33. `busy` is high for exactly 2W+1 = 33 cycles.
- Early-overflow path (only with `CUBE_SAT_EN`): SQ→FIN at E16, outputs valid and `busy` low after E17. `busy` is high for exactly W+1 = 17 cycles.
- `done` is high for exactly one cycle, the cycle after FIN.
- The next `start` can be accepted at the edge after `busy` falls, i.e. E34 on the normal path. The `done` cycle may coincide with a new acceptance.
- `result` and `ovf` change only at the FIN edge or on reset.

## Configuration
- `CUBE_SAT_EN` defined:
  - On overflow, `result` = all ones (2^W−1) and `ovf`=1.
  - The SQ-stage overflow takes the early W+1-cycle exit.
- `CUBE_SAT_EN` undefined:
  - CU always runs; latency is always 2W+1.
  - `result` = x^3 mod 2^W (low W bits, wrap-around). `ovf` is still reported.

## Test plan
- x=27, start pulse → after 33 busy cycles: `result`=19683, `ovf`=0, `done` pulses once.
- x=40 → 64000, `ovf`=0. Then x=41 → SAT: 65535, `ovf`=1. Non-SAT: 3385, `ovf`=1. Both take 33 cycles.
- x=0 → 0 and x=1 → 1, each in 33 cycles. Back-to-back requests issued on the `done` cycle are accepted.
- x=300 → SAT: `result`=65535, `ovf`=1, `busy` for 17 cycles. Non-SAT: `result`=64704, `ovf`=1, 33 cycles.
- Sequence: start x=5, then at cycle 10 assert start with x=9 → ignored. Result is 125.
- Drive `rst`=0 at cycle 20 of x=27 → `busy`, `result`, `ovf`, `done` go 0 immediately. After release, x=3 → 27.
